// File: rtl/mandelbrot_example_pipeline_credit_ctrl.sv
// Credit-based flow control around a fixed-latency, never-stalling pipeline.
// Upstream beats are admitted only while a FIFO slot is reserved for them,
// so the pipeline can run free and its output always has a landing place.
module mandelbrot_example_pipeline_credit_ctrl #(
  parameter int C_DWIDTH     = 32,
  parameter int C_DEPTH      = 3,
  parameter int C_FIFO_DEPTH = 8
) (
  input  logic                              aclk,
  input  logic                              areset,
  input  logic                              s_tvalid,
  output logic                              s_tready,
  input  logic [C_DWIDTH-1:0]               s_tdata,
  output logic [C_DWIDTH:0]                 p_din,
  output logic                              p_aclken,
  input  logic [C_DWIDTH:0]                 p_dout,
  output logic                              m_tvalid,
  input  logic                              m_tready,
  output logic [C_DWIDTH-1:0]               m_tdata,
  output logic [$clog2(C_FIFO_DEPTH+1)-1:0] level,
  output logic                              err_overflow
);

  localparam int LW = $clog2(C_FIFO_DEPTH + 1);
  localparam int AW = (C_FIFO_DEPTH > 1) ? $clog2(C_FIFO_DEPTH) : 1;
  localparam logic [LW-1:0] LP_FULL = LW'(C_FIFO_DEPTH);
  localparam logic [AW-1:0] LP_LAST = AW'(C_FIFO_DEPTH - 1);

  // The FIFO must hold every beat that can be in flight plus one, and the
  // pointer wrap below relies on a power-of-two depth.
  if ((C_FIFO_DEPTH < C_DEPTH + 1) || ((C_FIFO_DEPTH & (C_FIFO_DEPTH - 1)) != 0)
      || (C_DWIDTH < 1)) begin : g_bad_cfg
    $error("mandelbrot_example_pipeline_credit_ctrl: illegal parameter set");
  end

  // Control state
  logic [LW-1:0]       r_credits;
  logic [LW-1:0]       r_level;
  logic [AW-1:0]       r_wptr;
  logic [AW-1:0]       r_rptr;
  logic                r_tvalid;
  logic [C_DWIDTH-1:0] r_tdata;
  logic                r_err;

  // Storage (no reset needed; pointers and level qualify every read)
  logic [C_DWIDTH-1:0] r_mem [C_FIFO_DEPTH];

  // Per-cycle decode
  logic                w_accept;
  logic                w_pop;
  logic                w_in_vld;
  logic                w_full;
  logic                w_wr;
  logic                w_wr_err;
  logic [AW-1:0]       w_wptr_nxt;
  logic [AW-1:0]       w_rptr_nxt;
  logic [LW-1:0]       w_level_nxt;
  logic [LW-1:0]       w_credits_nxt;
  logic [C_DWIDTH-1:0] w_head_nxt;

  function automatic logic [AW-1:0] f_inc(input logic [AW-1:0] p);
    return (p == LP_LAST) ? '0 : p + AW'(1);
  endfunction

  // Ready depends only on reset and registered credits, never on valid/ready.
  assign s_tready = ~areset & (r_credits != '0);
  assign w_accept = s_tvalid & s_tready;
  assign p_din    = {w_accept, s_tdata};
  assign p_aclken = ~areset;

  assign w_in_vld = p_dout[C_DWIDTH];
  assign w_full   = (r_level == LP_FULL);
  assign w_wr     = w_in_vld & ~w_full;
  assign w_wr_err = w_in_vld & w_full;
  // Output valid mirrors level != 0, so a pop can never hit an empty FIFO.
  assign w_pop    = r_tvalid & m_tready;

  assign m_tvalid     = r_tvalid;
  assign m_tdata      = r_tdata;
  assign level        = r_level;
  assign err_overflow = r_err;

  // Next-state for pointers, occupancy, credits and the registered head word.
  always_comb begin
    w_wptr_nxt    = r_wptr;
    w_rptr_nxt    = r_rptr;
    w_level_nxt   = r_level;
    w_credits_nxt = r_credits;
    if (w_wr)  w_wptr_nxt = f_inc(r_wptr);
    if (w_pop) w_rptr_nxt = f_inc(r_rptr);
    case ({w_wr, w_pop})
      2'b10:   w_level_nxt = r_level + LW'(1);
      2'b01:   w_level_nxt = r_level - LW'(1);
      default: w_level_nxt = r_level;
    endcase
    // A credit is consumed at admission and returned only when the beat leaves.
    case ({w_accept, w_pop})
      2'b10:   w_credits_nxt = r_credits - LW'(1);
      2'b01:   w_credits_nxt = r_credits + LW'(1);
      default: w_credits_nxt = r_credits;
    endcase
    // The incoming word becomes the new head when it lands exactly in the
    // slot the read pointer will point at (empty FIFO, or last entry popped).
    w_head_nxt = r_mem[w_rptr_nxt];
    if (w_wr && (r_wptr == w_rptr_nxt)) w_head_nxt = p_dout[C_DWIDTH-1:0];
  end

  // Control registers; the sticky error clears only on reset.
  always_ff @(posedge aclk) begin
    if (areset) begin
      r_credits <= LP_FULL;
      r_level   <= '0;
      r_wptr    <= '0;
      r_rptr    <= '0;
      r_tvalid  <= 1'b0;
      r_err     <= 1'b0;
    end else begin
      r_credits <= w_credits_nxt;
      r_level   <= w_level_nxt;
      r_wptr    <= w_wptr_nxt;
      r_rptr    <= w_rptr_nxt;
      r_tvalid  <= (w_level_nxt != '0);
      r_err     <= r_err | w_wr_err;
    end
  end

  // FIFO storage write.
  always_ff @(posedge aclk) begin
    if (w_wr) r_mem[r_wptr] <= p_dout[C_DWIDTH-1:0];
  end

  // Registered head word; only meaningful while r_tvalid is set.
  always_ff @(posedge aclk) begin
    r_tdata <= w_head_nxt;
  end

endmodule

// File: tb/tb_mandelbrot_example_pipeline_credit_ctrl.sv
// Directed bench: models the attached enable-based delay pipeline and walks
// through single beat, backpressure, drain, simultaneous events, mid-stream
// reset and overflow injection.
module tb_mandelbrot_example_pipeline_credit_ctrl;

  localparam int DW = 32;
  localparam int DEPTH = 3;
  localparam int FDEPTH = 8;

  logic          aclk = 1'b0;
  logic          areset;
  logic          s_tvalid;
  logic          s_tready;
  logic [DW-1:0] s_tdata;
  logic [DW:0]   p_din;
  logic          p_aclken;
  logic [DW:0]   p_dout;
  logic          m_tvalid;
  logic          m_tready;
  logic [DW-1:0] m_tdata;
  logic [3:0]    level;
  logic          err_overflow;

  logic          force_en;
  logic [DW-1:0] force_data;
  logic [DW:0]   pipe [DEPTH];

  int n_assert = 0;
  int n_fail   = 0;
  int idx;

  always #5 aclk = ~aclk;

  mandelbrot_example_pipeline_credit_ctrl #(
    .C_DWIDTH(DW), .C_DEPTH(DEPTH), .C_FIFO_DEPTH(FDEPTH)
  ) dut (
    .aclk(aclk), .areset(areset),
    .s_tvalid(s_tvalid), .s_tready(s_tready), .s_tdata(s_tdata),
    .p_din(p_din), .p_aclken(p_aclken), .p_dout(p_dout),
    .m_tvalid(m_tvalid), .m_tready(m_tready), .m_tdata(m_tdata),
    .level(level), .err_overflow(err_overflow)
  );

  // Attached pipeline: enable-gated delay line whose valid bits clear on reset.
  always @(posedge aclk) begin
    if (areset) begin
      for (int i = 0; i < DEPTH; i++) pipe[i] <= '0;
    end else if (p_aclken) begin
      pipe[0] <= p_din;
      for (int i = 1; i < DEPTH; i++) pipe[i] <= pipe[i-1];
    end
  end

  assign p_dout = force_en ? {1'b1, force_data} : pipe[DEPTH-1];

  task automatic chk(input string tag, input logic [63:0] obs, input logic [63:0] exp);
    n_assert++;
    assert (obs === exp) else begin
      n_fail++;
      $error("FAIL %s: observed=%0h expected=%0h", tag, obs, exp);
    end
  endtask

  task automatic nxt();
    @(posedge aclk);
    #1;
  endtask

  initial begin
    areset = 1'b1; s_tvalid = 1'b1; s_tdata = 32'hA5A5A5A5;
    m_tready = 1'b0; force_en = 1'b0; force_data = '0;

    // Reset window
    nxt(); #1;
    chk("rst_s_tready", s_tready, 0);
    chk("rst_aclken", p_aclken, 0);
    chk("rst_accept", p_din[DW], 0);
    nxt();
    areset = 1'b0; s_tvalid = 1'b0; #1;
    chk("post_rst_level", level, 0);
    chk("post_rst_m_tvalid", m_tvalid, 0);
    chk("post_rst_err", err_overflow, 0);
    chk("post_rst_s_tready", s_tready, 1);
    chk("post_rst_aclken", p_aclken, 1);
    nxt();

    // Single beat: accepted in cycle 0, visible in cycle 4
    s_tvalid = 1'b1; s_tdata = 32'h12345678; m_tready = 1'b1; #1;
    chk("sb_p_din", p_din, {1'b1, 32'h12345678});
    nxt();
    s_tvalid = 1'b0;
    for (int c = 1; c < 4; c++) begin
      #1; chk("sb_early_valid", m_tvalid, 0); nxt();
    end
    #1;
    chk("sb_m_tvalid", m_tvalid, 1);
    chk("sb_m_tdata", m_tdata, 32'h12345678);
    chk("sb_level1", level, 1);
    nxt(); #1;
    chk("sb_level0", level, 0);
    chk("sb_valid0", m_tvalid, 0);
    chk("sb_s_tready", s_tready, 1);
    nxt();

    // Full backpressure: stream 0..9 with m_tready low
    idx = 0;
    for (int c = 0; c < 12; c++) begin
      s_tvalid = 1'b1; s_tdata = 32'(idx); m_tready = 1'b0; #1;
      chk("bp_s_tready", s_tready, (c < 8));
      if (c >= 4) begin
        chk("bp_m_tvalid", m_tvalid, 1);
        chk("bp_hold_data", m_tdata, 0);
      end
      if (c == 11) begin
        chk("bp_level8", level, 8);
        chk("bp_err", err_overflow, 0);
      end
      if (s_tready) idx++;
      nxt();
    end

    // Drain in order, remaining beats 8 and 9 follow
    for (int d = 0; d < 10; d++) begin
      s_tvalid = (idx < 10); s_tdata = 32'(idx); m_tready = 1'b1; #1;
      chk("dr_m_tvalid", m_tvalid, 1);
      chk("dr_m_tdata", m_tdata, 64'(d));
      if (d == 0) chk("dr_ready_first", s_tready, 0);
      if (d == 1) chk("dr_ready_after_pop", s_tready, 1);
      if (s_tvalid && s_tready) idx++;
      nxt();
    end
    s_tvalid = 1'b0; #1;
    chk("dr_empty_valid", m_tvalid, 0);
    chk("dr_empty_level", level, 0);
    m_tready = 1'b0;
    nxt();

    // Simultaneous events: fill 7 beats so credits = 1
    for (int i = 0; i < 7; i++) begin
      s_tvalid = 1'b1; s_tdata = 32'h100 + 32'(i); #1;
      chk("sim_fill_ready", s_tready, 1);
      nxt();
    end
    s_tvalid = 1'b0;
    for (int w = 0; w < 3; w++) begin
      #1; chk("sim_credit1_ready", s_tready, 1); nxt();
    end
    s_tvalid = 1'b1; s_tdata = 32'h107; m_tready = 1'b1; #1;
    chk("sim_level7", level, 7);
    chk("sim_head", m_tdata, 32'h100);
    chk("sim_ready_acc", s_tready, 1);
    nxt();
    s_tvalid = 1'b0; m_tready = 1'b0; #1;
    chk("sim_credit_hold", s_tready, 1);
    chk("sim_level6", level, 6);
    nxt(); #1;
    chk("sim_level6b", level, 6);
    nxt();
    m_tready = 1'b1; #1;
    chk("sim_wrpop_before", level, 6);
    chk("sim_wrpop_head", m_tdata, 32'h101);
    nxt();
    m_tready = 1'b0; #1;
    chk("sim_wrpop_level", level, 6);
    chk("sim_wrpop_next", m_tdata, 32'h102);
    nxt();
    for (int k = 2; k < 8; k++) begin
      m_tready = 1'b1; #1;
      chk("sim_drain_valid", m_tvalid, 1);
      chk("sim_drain_data", m_tdata, 32'h100 + 32'(k));
      nxt();
    end
    m_tready = 1'b0; #1;
    chk("sim_drain_empty", m_tvalid, 0);
    chk("sim_drain_level", level, 0);
    nxt();

    // Reset mid-operation: 3 in FIFO, 2 in flight
    for (int i = 0; i < 5; i++) begin
      s_tvalid = 1'b1; s_tdata = 32'h200 + 32'(i); #1; nxt();
    end
    s_tvalid = 1'b0; #1; nxt();
    #1;
    chk("mr_level3", level, 3);
    areset = 1'b1;
    nxt();
    areset = 1'b0; #1;
    chk("mr_valid0", m_tvalid, 0);
    chk("mr_level0", level, 0);
    chk("mr_ready", s_tready, 1);
    nxt();
    for (int c = 0; c < 10; c++) begin
      #1;
      chk("mr_no_stale_valid", m_tvalid, 0);
      chk("mr_no_stale_level", level, 0);
      nxt();
    end

    // Full credits after reset, then overflow injection at level 8
    idx = 0;
    for (int c = 0; c < 12; c++) begin
      s_tvalid = 1'b1; s_tdata = 32'h300 + 32'(idx); #1;
      chk("ov_cred8_ready", s_tready, (c < 8));
      if (s_tready) idx++;
      nxt();
    end
    s_tvalid = 1'b0; #1;
    chk("ov_level8", level, 8);
    chk("ov_err_before", err_overflow, 0);
    chk("ov_head", m_tdata, 32'h300);
    force_data = 32'hDEADBEEF; force_en = 1'b1;
    nxt();
    force_en = 1'b0; #1;
    chk("ov_level_kept", level, 8);
    chk("ov_err_set", err_overflow, 1);
    chk("ov_head_kept", m_tdata, 32'h300);
    chk("ov_valid_kept", m_tvalid, 1);
    nxt(); nxt(); nxt(); #1;
    chk("ov_err_sticky", err_overflow, 1);
    areset = 1'b1;
    nxt();
    areset = 1'b0; #1;
    chk("ov_err_cleared", err_overflow, 0);
    chk("ov_level_cleared", level, 0);
    nxt();

    $display("End of test - %0d assertions evaluated, %0d failures", n_assert, n_fail);
    $finish;
  end

endmodule
